// File: rtl/tc_pl_cap_seq.sv
// Capture sequencer for the PL sample buffer: start request -> pre/post-trigger
// capture into a circular buffer, with trigger position and status reporting.
module tc_pl_cap_seq #(
  parameter int unsigned AW = 12,
  parameter int unsigned CW = 32
) (
  input  logic          clk125,
  input  logic          rst,
  input  logic          cap_trig,
  input  logic          cap_abort,
  input  logic [AW-1:0] cfg_pre,
  input  logic [AW-1:0] cfg_post,
  input  logic [CW-1:0] cfg_tmo,
  input  logic          hw_trig,
  input  logic          smp_vld,
  output logic          buf_we,
  output logic [AW-1:0] buf_addr,
  output logic [AW-1:0] trig_addr,
  output logic          cap_cing,
  output logic          cap_cmpt,
  output logic          cap_tmo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARM,
    S_POST,
    S_DONE
  } state_t;

  state_t        state, state_n;
  logic          cap_trig_q, hw_trig_q;
  logic [AW-1:0] pre_l, post_l, pre_cnt, post_cnt, wr_ptr;
  logic [CW-1:0] tmo_l, tmo_cnt;
  logic          start, hw_edge, tmo_hit, trig_fire, wr_issue;

  always_ff @(posedge clk125) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start     = 1'b0;
    trig_fire = 1'b0;
    wr_issue  = 1'b0;
    cap_cmpt  = 1'b0;
    cap_cing  = (state != S_IDLE);
    hw_edge   = hw_trig & ~hw_trig_q;
    tmo_hit   = (tmo_l != '0) && (tmo_cnt == tmo_l - CW'(1));
    case (state)
      S_IDLE: begin
        if (cap_trig && !cap_trig_q) begin
          start   = 1'b1;
          state_n = S_PRE;
        end
      end
      S_PRE: begin
        if (cap_abort) begin
          state_n = S_IDLE;
        end else if (pre_l == '0) begin
          state_n = S_ARM;
        end else if (smp_vld) begin
          // Leave PRE on the write that completes the pre count so no sample is dropped.
          wr_issue = 1'b1;
          if (pre_cnt == pre_l - AW'(1)) state_n = S_ARM;
        end
      end
      S_ARM: begin
        if (cap_abort) begin
          state_n = S_IDLE;
        end else begin
          wr_issue = smp_vld;
          if (hw_edge || tmo_hit) begin
            trig_fire = 1'b1;
            if (smp_vld && (post_l == AW'(1))) state_n = S_DONE;
            else                               state_n = S_POST;
          end
        end
      end
      S_POST: begin
        if (cap_abort) begin
          state_n = S_IDLE;
        end else if (smp_vld) begin
          wr_issue = 1'b1;
          if (post_cnt == post_l - AW'(1)) state_n = S_DONE;
        end
      end
      S_DONE: begin
        cap_cmpt = ~cap_abort;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk125) begin
    if (rst) begin
      cap_trig_q <= 1'b1;
      hw_trig_q  <= 1'b0;
      pre_l      <= '0;
      post_l     <= '0;
      tmo_l      <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      tmo_cnt    <= '0;
      wr_ptr     <= '0;
      buf_we     <= 1'b0;
      buf_addr   <= '0;
      trig_addr  <= '0;
      cap_tmo    <= 1'b0;
    end else begin
      cap_trig_q <= cap_trig;
      hw_trig_q  <= hw_trig;
      buf_we     <= wr_issue;
      if (wr_issue) begin
        buf_addr <= wr_ptr;
        wr_ptr   <= wr_ptr + AW'(1);
      end
      if (start) begin
        pre_l    <= cfg_pre;
        post_l   <= (cfg_post == '0) ? AW'(1) : cfg_post;
        tmo_l    <= cfg_tmo;
        pre_cnt  <= '0;
        post_cnt <= '0;
        tmo_cnt  <= '0;
        cap_tmo  <= 1'b0;
      end
      if (wr_issue && state == S_PRE) pre_cnt <= pre_cnt + AW'(1);
      if (state == S_ARM && !cap_abort) tmo_cnt <= tmo_cnt + CW'(1);
      // The trigger-cycle sample, if any, is the first post sample.
      if (trig_fire) begin
        trig_addr <= wr_ptr;
        cap_tmo   <= ~hw_edge;
        post_cnt  <= AW'(smp_vld);
      end
      if (wr_issue && state == S_POST) post_cnt <= post_cnt + AW'(1);
    end
  end

endmodule

// File: tb/tb_tc_pl_cap_seq.sv
// Scoreboarded bench for tc_pl_cap_seq: per-capture stimulus vectors are turned
// into expected write/complete events by a phase-walk model; a monitor pops them.
module tb_tc_pl_cap_seq;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 16;
  localparam int L    = 400;
  localparam int RING = 1 << AW;

  logic          clk125 = 1'b0;
  logic          rst = 1'b1;
  logic          cap_trig = 1'b0;
  logic          cap_abort = 1'b0;
  logic          hw_trig = 1'b0;
  logic          smp_vld = 1'b0;
  logic [AW-1:0] cfg_pre = '0;
  logic [AW-1:0] cfg_post = '0;
  logic [CW-1:0] cfg_tmo = '0;
  logic          buf_we, cap_cing, cap_cmpt, cap_tmo;
  logic [AW-1:0] buf_addr, trig_addr;

  tc_pl_cap_seq #(.AW(AW), .CW(CW)) dut (
    .clk125   (clk125),
    .rst      (rst),
    .cap_trig (cap_trig),
    .cap_abort(cap_abort),
    .cfg_pre  (cfg_pre),
    .cfg_post (cfg_post),
    .cfg_tmo  (cfg_tmo),
    .hw_trig  (hw_trig),
    .smp_vld  (smp_vld),
    .buf_we   (buf_we),
    .buf_addr (buf_addr),
    .trig_addr(trig_addr),
    .cap_cing (cap_cing),
    .cap_cmpt (cap_cmpt),
    .cap_tmo  (cap_tmo)
  );

  always #4 clk125 = ~clk125;

  typedef struct {
    bit is_cmpt;
    int addr;
    bit tmo;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  wp = 0;
  int  m_trig = 0;
  bit  m_tmo = 1'b0;
  int  end_k = 0;
  bit  vld_v[L];
  bit  hw_v[L];
  bit  trg_v[L];
  bit  abt_v[L];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: a write due in the same cycle as the completion is queued first.
  initial begin
    ev_t ev;
    bit  have;
    forever begin
      @(negedge clk125);
      if (!rst) begin
        if (buf_we) begin
          have = (exp_q.size() > 0) && !exp_q[0].is_cmpt;
          chk("write_expected", int'(have), 1);
          if (have) begin
            ev = exp_q.pop_front();
            chk("buf_addr", int'(buf_addr), ev.addr);
          end
        end
        if (cap_cmpt) begin
          have = (exp_q.size() > 0) && exp_q[0].is_cmpt;
          chk("cmpt_expected", int'(have), 1);
          if (have) begin
            ev = exp_q.pop_front();
            chk("cmpt_trig_addr", int'(trig_addr), ev.addr);
            chk("cmpt_tmo", int'(cap_tmo), int'(ev.tmo));
            chk("cmpt_cing", int'(cap_cing), 1);
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic push_wr();
    ev_t ev;
    ev.is_cmpt = 1'b0;
    ev.addr    = wp;
    ev.tmo     = 1'b0;
    exp_q.push_back(ev);
    wp = (wp + 1) % RING;
  endtask

  // Walk the stimulus vectors through the capture phases described for the block.
  // Index k is the k-th clock edge after (k=0) the edge that samples the start.
  task automatic predict(input int pre, input int post, input int tmo);
    int  k, n, a, pe;
    bit  live, hit_hw;
    ev_t ev;
    abt_v[L-1] = 1'b1;
    pe     = (post == 0) ? 1 : post;
    live   = 1'b1;
    m_tmo  = 1'b0;
    hit_hw = 1'b0;
    k      = 1;
    if (pre == 0) begin
      if (abt_v[1]) live = 1'b0;
      else k = 2;
    end else begin
      n = 0;
      while (live && n < pre) begin
        if (abt_v[k]) live = 1'b0;
        else begin
          if (vld_v[k]) begin push_wr(); n++; end
          k++;
        end
      end
    end
    a = 0;
    while (live) begin
      if (abt_v[k]) live = 1'b0;
      else begin
        a++;
        hit_hw = hw_v[k] && !hw_v[k-1];
        if (hit_hw || (tmo != 0 && a == tmo)) break;
        if (vld_v[k]) push_wr();
        k++;
      end
    end
    if (live) begin
      m_trig = wp;
      m_tmo  = !hit_hw;
      n = 0;
      if (vld_v[k]) begin push_wr(); n = 1; end
      k++;
      while (live && n < pe) begin
        if (abt_v[k]) live = 1'b0;
        else begin
          if (vld_v[k]) begin push_wr(); n++; end
          k++;
        end
      end
    end
    if (live && !abt_v[k]) begin
      ev.is_cmpt = 1'b1;
      ev.addr    = m_trig;
      ev.tmo     = m_tmo;
      exp_q.push_back(ev);
    end
    end_k = k;
  endtask

  task automatic clr_vec();
    for (int k = 0; k < L; k++) begin
      vld_v[k] = 1'b0; hw_v[k] = 1'b0; trg_v[k] = 1'b0; abt_v[k] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cap_trig  = 1'b0;
      cap_abort = 1'b0;
      hw_trig   = 1'b0;
      smp_vld   = 1'($urandom);
      cfg_pre   = AW'($urandom);
      cfg_post  = AW'($urandom);
      cfg_tmo   = CW'($urandom);
      @(posedge clk125); #1;
    end
  endtask

  task automatic run(input int pre, input int post, input int tmo);
    bit ok_cing;
    trg_v[0] = 1'b1;
    hw_v[0]  = 1'b0;
    abt_v[0] = 1'b0;
    predict(pre, post, tmo);
    for (int k = end_k; k < L; k++) trg_v[k] = 1'b0;
    ok_cing = 1'b1;
    for (int k = 0; k <= end_k; k++) begin
      cap_trig  = trg_v[k];
      smp_vld   = vld_v[k];
      hw_trig   = hw_v[k];
      cap_abort = abt_v[k];
      if (k == 0) begin
        cfg_pre  = AW'(pre);
        cfg_post = AW'(post);
        cfg_tmo  = CW'(tmo);
      end else begin
        cfg_pre  = AW'($urandom);
        cfg_post = AW'($urandom);
        cfg_tmo  = CW'($urandom);
      end
      @(posedge clk125); #1;
      if (k == 0) chk("tmo_clear_at_start", int'(cap_tmo), 0);
      if (cap_cing !== (k < end_k)) ok_cing = 1'b0;
      if (k == end_k) chk("we_low_after_end", int'(buf_we), 0);
    end
    chk("cing_window", int'(ok_cing), 1);
    idle(4);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    chk("trig_addr_held", int'(trig_addr), m_trig);
    chk("tmo_flag", int'(cap_tmo), int'(m_tmo));
  endtask

  task automatic gen_rand(output int pre, output int post, output int tmo);
    pre  = $urandom_range(0, 15);
    post = $urandom_range(0, 15);
    tmo  = ($urandom % 2 == 1) ? $urandom_range(1, 40) : 0;
    clr_vec();
    for (int k = 1; k < L; k++) begin
      vld_v[k] = ($urandom % 10) < 7;
      trg_v[k] = ($urandom % 4) == 0;
      hw_v[k]  = (($urandom % 6) == 0) ? !hw_v[k-1] : hw_v[k-1];
    end
    if ($urandom % 5 == 0) abt_v[$urandom_range(1, 60)] = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_buf_we"},    int'(buf_we),    0);
    chk({tag, "_buf_addr"},  int'(buf_addr),  0);
    chk({tag, "_trig_addr"}, int'(trig_addr), 0);
    chk({tag, "_cap_cing"},  int'(cap_cing),  0);
    chk({tag, "_cap_cmpt"},  int'(cap_cmpt),  0);
    chk({tag, "_cap_tmo"},   int'(cap_tmo),   0);
  endtask

  initial begin
    int pre, post, tmo;

    // Start request held high through reset must not start a capture.
    cap_trig = 1'b1;
    repeat (4) @(posedge clk125);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk125);
    #1;
    chk("held_trig_no_start", int'(cap_cing), 0);
    idle(3);

    // Basic capture from ring position 0, hw trigger after 10 ARM cycles,
    // second start edge during POST.
    clr_vec();
    for (int k = 1; k < L; k++) vld_v[k] = 1'b1;
    for (int k = 15; k < L; k++) hw_v[k] = 1'b1;
    trg_v[17] = 1'b1; trg_v[18] = 1'b1;
    run(4, 4, 0);
    chk("t1_trig_addr", int'(trig_addr), 14);

    // Advance ring to 14, then capture across the wrap.
    clr_vec();
    for (int k = 1; k < L; k++) vld_v[k] = 1'b1;
    for (int k = 2; k < L; k++) hw_v[k] = 1'b1;
    run(0, 12, 0);
    clr_vec();
    for (int k = 1; k < L; k++) vld_v[k] = 1'b1;
    for (int k = 16; k < L; k++) hw_v[k] = 1'b1;
    run(12, 8, 0);
    chk("wrap_trig_addr", int'(trig_addr), 13);

    // Forced trigger by timeout with hw_trig low.
    clr_vec();
    for (int k = 1; k < L; k++) vld_v[k] = ($urandom % 10) < 6;
    run(2, 3, 100);
    chk("tmo_forced", int'(cap_tmo), 1);

    // hw_trig already high when ARM is entered: no trigger, timeout instead.
    clr_vec();
    for (int k = 1; k < L; k++) begin vld_v[k] = 1'b1; hw_v[k] = 1'b1; end
    run(3, 2, 20);
    chk("level_high_no_trig", int'(cap_tmo), 1);

    // Abort mid-POST.
    clr_vec();
    for (int k = 1; k < L; k++) vld_v[k] = 1'b1;
    for (int k = 4; k < L; k++) hw_v[k] = 1'b1;
    abt_v[8] = 1'b1;
    run(2, 10, 0);

    // cfg_pre=0, cfg_post=0: a single write on the trigger cycle.
    clr_vec();
    vld_v[1] = 1'b1; vld_v[3] = 1'b1;
    for (int k = 3; k < L; k++) hw_v[k] = 1'b1;
    run(0, 0, 0);

    // hw edge coinciding with timeout counts as a hardware trigger.
    clr_vec();
    for (int k = 1; k < L; k++) vld_v[k] = 1'b1;
    for (int k = 6; k < L; k++) hw_v[k] = 1'b1;
    run(1, 2, 5);
    chk("simul_hw_wins", int'(cap_tmo), 0);

    for (int i = 0; i < 30; i++) begin
      gen_rand(pre, post, tmo);
      run(pre, post, tmo);
    end

    // Reset asserted while in ARM.
    cfg_pre = '0; cfg_post = AW'(5); cfg_tmo = '0;
    smp_vld = 1'b0; hw_trig = 1'b0; cap_abort = 1'b0;
    cap_trig = 1'b1;
    repeat (4) @(posedge clk125);
    #1;
    chk("armed_before_rst", int'(cap_cing), 1);
    rst = 1'b1;
    @(posedge clk125); #1;
    chk_reset_vals("rst_in_arm");
    @(posedge clk125); #1;
    rst = 1'b0;
    wp = 0; m_trig = 0; m_tmo = 1'b0;
    idle(3);
    chk("idle_after_rst", int'(cap_cing), 0);

    // Capture after reset restarts at ring position 0.
    clr_vec();
    for (int k = 1; k < L; k++) vld_v[k] = 1'b1;
    for (int k = 15; k < L; k++) hw_v[k] = 1'b1;
    run(4, 4, 0);
    chk("post_rst_trig_addr", int'(trig_addr), 14);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tc_pl_cap_seq.md
# tc_pl_cap_seq

Capture sequencer for the PL sample buffer. It turns the PS start request into a complete pre/post-trigger capture into a circular buffer. It generates buffer write strobes and addresses, records the trigger position, and reports `cap_cing` / `cap_cmpt` to the GP status logic that the PS polls.

## Interface
Parameters:
- AW, 12, buffer address width; buffer depth is 2^AW samples
- CW, 32, trigger-timeout counter width

Ports:
- clk125  in  1  system clock; all logic single-domain
- rst  in  1  reset, synchronous, active-high
- cap_trig  in  1  PS start request (GP level); a rising edge starts a capture
- cap_abort  in  1  PS abort; level, honoured in any busy state
- cfg_pre  in  AW  pre-trigger sample count; latched at start
- cfg_post  in  AW  post-trigger sample count, including the trigger sample; latched at start; 0 treated as 1
- cfg_tmo  in  CW  ARM timeout in clk125 cycles; 0 = no timeout; latched at start
- hw_trig  in  1  hardware trigger; level, rising edge detected internally
- smp_vld  in  1  one-cycle sample-valid strobe from the ADC front end
- buf_we  out  1  buffer write enable
- buf_addr  out  AW  buffer write address
- trig_addr  out  AW  buffer address of the trigger sample; held until the next start
- cap_cing  out  1  capture in progress
- cap_cmpt  out  1  one-cycle capture-complete pulse
- cap_tmo  out  1  sticky: last capture was force-triggered by timeout; cleared at next start

## Operation
- States:
  - IDLE: waits for a rising edge of cap_trig. On the edge it latches cfg_*, zeroes the counters, clears cap_tmo, and enters PRE. Edges while busy are ignored.
  - PRE: every smp_vld writes at buf_addr, then buf_addr increments mod 2^AW and pre_cnt increments. The state enters ARM when pre_cnt == cfg_pre. If cfg_pre == 0, the state goes to ARM on the next cycle with no writes.
  - ARM: writing continues in the ring. A rising edge of hw_trig enters POST. The timeout counter increments every cycle. When it reaches a nonzero cfg_tmo, a forced trigger occurs and cap_tmo is set.
    - On the trigger cycle, trig_addr captures the address the next written sample will use.
    - A sample with smp_vld on the trigger cycle is the trigger sample and counts as the first post sample.
  - POST: samples are written until post_cnt == max(cfg_post, 1), then the state enters DONE.
  - DONE: lasts one cycle, drives cap_cmpt = 1, then returns to IDLE.
- Abort: cap_abort in PRE, ARM, POST or DONE returns to IDLE on the next cycle. No cap_cmpt pulse is produced. trig_addr and cap_tmo are left as they are.
- If cfg_pre + cfg_post > 2^AW, the oldest pre samples are overwritten by the ring. This is not an error.
- buf_addr is not reset at start. Captures continue from the current ring position, and software locates data via trig_addr.
- The hw_trig edge detector runs in all states, so a level already high when ARM is entered does not trigger.
- The cap_trig edge register resets to 1, so a request held high through reset does not start a capture.
- Reset values: state IDLE; buf_we 0; buf_addr 0; trig_addr 0; cap_cing 0; cap_cmpt 0; cap_tmo 0; all counters 0.

## Timing
- The cap_trig rising edge is sampled at cycle T. The state is PRE and cap_cing = 1 from T+1.
- buf_we / buf_addr are registered and assert the cycle after the qualifying smp_vld. The front end delays sample data by one cycle to align with them.
- cap_cing = 1 in PRE, ARM, POST and DONE. It falls in the cycle after DONE, coincident with cap_cmpt falling.
- cap_cmpt rises the cycle after the final post write is issued, which is the same cycle buf_we for that sample is high.
- Simultaneous hw_trig edge and timeout: the capture is treated as a hardware trigger and cap_tmo stays 0.
- Simultaneous abort and any other event: abort wins.
- rst has priority over everything.

## Test plan
- cfg_pre=4, cfg_post=4, smp_vld every cycle, start at buf_addr=0, hw_trig after 10 ARM cycles:
  - 4 writes at addresses 0–3, then ring writes continue through ARM.
  - trig_addr = first post address.
  - 4 post writes, then one cap_cmpt pulse; cap_cing high throughout.
- AW=4, cfg_pre=12, cfg_post=8, with buf_addr starting at 14: addresses wrap 15→0, trig_addr wraps correctly, and exactly 8 post writes occur.
- cfg_tmo=100, hw_trig held low: the forced trigger occurs at ARM cycle 100, cap_tmo=1, and cap_cmpt pulses. The next start clears cap_tmo.
- cap_abort asserted mid-POST: returns to IDLE next cycle, buf_we stops, cap_cing=0, no cap_cmpt.
- cfg_pre=0, cfg_post=0: enters ARM immediately. The trigger with smp_vld on the trigger cycle produces exactly one write, then cap_cmpt.
- cap_trig held high across reset gives no start; a second cap_trig edge during POST is ignored; rst asserted in ARM returns all outputs to reset values.
